regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp: multi-ported register file with a per-register scoreboard.
//
// Optional feature macro: REGFILE_MP_BYPASS_EN. When defined, same-cycle write
// data is forwarded to matching read ports. When undefined, reads return
// stored state only.
//
// Parameters:
//   XLEN  register data width
//   NREG  register count (power of two, >= 2)
//   NRD   read-port count
//   NWR   write-port count
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     per-write-port enable             [NWR]
//   wr_addr   write index, port k at [k*AW +: AW]
//   wr_data   write data, port k at [k*XLEN +: XLEN]
//   rd_addr   read index per read port
//   rd_data   read data per read port
//   rd_busy   scoreboard bit of the addressed register per read port
//   rsv_en    reserve request (marks rsv_addr pending)
//   rsv_addr  register to reserve
//   busy_vec  full scoreboard, bit i = register i pending
//
// Register 0 always reads 0 and can never be written or reserved.
// ---------------------------------------------------------------------------
module regfile_mp #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWR  = 2,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic [NREG-1:0]     busy_vec
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;

   // Next state. Ports are walked in ascending order so the highest-numbered
   // port targeting a register wins. The reserve is applied after the write
   // clears so a new producer overrides a retiring one.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int k = 0; k < NWR; k++) begin
         if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
            regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
            busy_d[wr_addr[k*AW +: AW]] = 1'b0;
         end
      end
      if (rsv_en) begin
         busy_d[rsv_addr] = 1'b1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read ports.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int r = 0; r < NRD; r++) begin
         rd_data[r*XLEN +: XLEN] = regs_q[rd_addr[r*AW +: AW]];
         rd_busy[r]              = busy_q[rd_addr[r*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
         for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr[r*AW +: AW])) begin
               rd_data[r*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
               // Forwarded value retires the producer unless a new one reserves now.
               rd_busy[r] = rsv_en && (rsv_addr == rd_addr[r*AW +: AW]);
            end
         end
`endif
         // x0 is never bypassed; nothing leaks out while reset is held.
         if ((rd_addr[r*AW +: AW] == '0) || !rst_n) begin
            rd_data[r*XLEN +: XLEN] = '0;
            rd_busy[r]              = 1'b0;
         end
      end
   end

   assign busy_vec = busy_q;

endmodule
